// File: rtl/ring_pkg.sv
// Shared constants and enums for the ring write arbiter and its round-robin picker.
package ring_pkg;

    localparam int DefWordSize   = 8;
    localparam int DefLengthBits = 3;
    localparam int DefNumReq     = 4;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_READ_WAIT = 1'b1
    } state_t;

    typedef enum logic {
        KIND_READ  = 1'b0,
        KIND_WRITE = 1'b1
    } kind_t;

    // Index width that stays legal for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request after the last winner, wrapping.
module rr_picker
    import ring_pkg::*;
#(
    parameter int  NumReq = DefNumReq,
    localparam int IdxW   = idx_width(NumReq)
) (
    input  logic [NumReq-1:0] i_req,
    input  logic [IdxW-1:0]   i_last_winner,
    output logic [IdxW-1:0]   o_winner,
    output logic              o_any_valid
);

    int w_idx;

    always_comb begin
        o_winner    = '0;
        o_any_valid = 1'b0;
        w_idx       = 0;
        for (int k = 1; k <= NumReq; k++) begin
            w_idx = (int'(i_last_winner) + k) % NumReq;
            if (!o_any_valid && i_req[w_idx]) begin
                o_any_valid = 1'b1;
                o_winner    = IdxW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/ring_write_arbiter.sv
// Arbitrates NumReq writers and one reader onto a single-port ring buffer, tracking occupancy.
module ring_write_arbiter
    import ring_pkg::*;
#(
    parameter int NumReq     = DefNumReq,
    parameter int WordSize   = DefWordSize,
    parameter int LengthBits = DefLengthBits
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NumReq-1:0]          reqValid,
    input  logic [NumReq*WordSize-1:0] reqData,
    output logic [NumReq-1:0]          reqAck,
    input  logic                       rdReq,
    output logic                       rdValid,
    output logic [WordSize-1:0]        rdData,
    output logic                       bufWriteEnable,
    output logic [WordSize-1:0]        bufWrite,
    output logic                       bufReadEnable,
    input  logic                       bufReadAck,
    input  logic [WordSize-1:0]        bufRead,
    output logic [LengthBits:0]        level,
    output logic                       full,
    output logic                       empty,
    output state_t                     o_dbg_state
);

    localparam int                  IdxW         = idx_width(NumReq);
    localparam logic [LengthBits:0] BufferLength = (LengthBits + 1)'(2 ** LengthBits);
    localparam logic [IdxW-1:0]     LastIdx      = IdxW'(NumReq - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [NumReq-1:0]     r_reqAck;
    logic                  r_bufWriteEnable;
    logic [WordSize-1:0]   r_bufWrite;
    logic                  r_bufReadEnable;
    logic                  r_rdValid;
    logic [WordSize-1:0]   r_rdData;
    logic [LengthBits:0]   r_level;
    logic [IdxW-1:0]       r_last_winner;
    kind_t                 r_last_kind;

    logic [NumReq-1:0]     w_req_masked;
    logic [IdxW-1:0]       w_winner;
    logic                  w_any_valid;
    logic                  w_wr_cand;
    logic                  w_rd_cand;
    logic                  w_do_write;
    logic                  w_do_read;
    logic                  w_read_done;
    logic                  w_read_fail;

    // Handshake: a requester holds reqValid/reqData until it sees its one-cycle reqAck,
    // which is the accept; while reqAck[i] is high requester i is masked so a held word
    // is never taken twice. rdReq is a level; each accepted read returns one rdValid pulse.
    assign w_req_masked = reqValid & ~r_reqAck;

    rr_picker #(
        .NumReq(NumReq)
    ) u_rr_picker (
        .i_req        (w_req_masked),
        .i_last_winner(r_last_winner),
        .o_winner     (w_winner),
        .o_any_valid  (w_any_valid)
    );

    assign w_wr_cand = w_any_valid && (r_level != BufferLength);
    assign w_rd_cand = rdReq && (r_level != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // READ_WAIT spans the enable cycle plus one quiet cycle in which the buffer answers.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:      if (w_do_read) w_state_next = ST_READ_WAIT;
            ST_READ_WAIT: if (!r_bufReadEnable) w_state_next = ST_IDLE;
            default:      w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_do_write  = 1'b0;
        w_do_read   = 1'b0;
        w_read_done = 1'b0;
        w_read_fail = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_do_write = w_wr_cand && (!w_rd_cand || r_last_kind == KIND_READ);
                w_do_read  = w_rd_cand && !w_do_write;
            end
            ST_READ_WAIT: begin
                w_read_done = !r_bufReadEnable && bufReadAck;
                w_read_fail = !r_bufReadEnable && !bufReadAck;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_reqAck         <= '0;
            r_bufWriteEnable <= 1'b0;
            r_bufWrite       <= '0;
            r_bufReadEnable  <= 1'b0;
            r_rdValid        <= 1'b0;
            r_rdData         <= '0;
            r_level          <= '0;
            r_last_winner    <= LastIdx;
            r_last_kind      <= KIND_READ;
        end else begin
            r_reqAck         <= '0;
            r_bufWriteEnable <= w_do_write;
            r_bufReadEnable  <= w_do_read;
            r_rdValid        <= w_read_done;
            if (w_do_write) begin
                r_reqAck[w_winner] <= 1'b1;
                r_bufWrite         <= reqData[int'(w_winner) * WordSize +: WordSize];
                r_last_winner      <= w_winner;
                r_last_kind        <= KIND_WRITE;
                r_level            <= r_level + 1'b1;
            end
            if (w_do_read) begin
                r_last_kind <= KIND_READ;
            end
            if (w_read_done) begin
                r_rdData <= bufRead;
                r_level  <= r_level - 1'b1;
            end
        end
    end

    // A missing bufReadAck drops the read without touching level.
    a_read_ack : assert property (@(posedge clk) disable iff (reset) !w_read_fail)
        else $error("ring_write_arbiter: no bufReadAck in READ_WAIT, read dropped");

    assign reqAck         = r_reqAck;
    assign bufWriteEnable = r_bufWriteEnable;
    assign bufWrite       = r_bufWrite;
    assign bufReadEnable  = r_bufReadEnable;
    assign rdValid        = r_rdValid;
    assign rdData         = r_rdData;
    assign level          = r_level;
    assign full           = (r_level == BufferLength);
    assign empty          = (r_level == '0);
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_ring_write_arbiter.sv
// Randomized bench for ring_write_arbiter: buffer model, requester drivers, cycle reference model, scoreboard.
module tb_ring_write_arbiter;
    import ring_pkg::*;

    localparam int NR = 4;
    localparam int WS = 8;
    localparam int LB = 3;
    localparam int BL = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     reqValid;
    logic [NR*WS-1:0]  reqData;
    logic [NR-1:0]     reqAck;
    logic              rdReq;
    logic              rdValid;
    logic [WS-1:0]     rdData;
    logic              bufWriteEnable;
    logic [WS-1:0]     bufWrite;
    logic              bufReadEnable;
    logic              bufReadAck;
    logic [WS-1:0]     bufRead;
    logic [LB:0]       level;
    logic              full;
    logic              empty;
    state_t            dbg_state;

    ring_write_arbiter #(.NumReq(NR), .WordSize(WS), .LengthBits(LB)) dut (
        .clk           (clk),
        .reset         (reset),
        .reqValid      (reqValid),
        .reqData       (reqData),
        .reqAck        (reqAck),
        .rdReq         (rdReq),
        .rdValid       (rdValid),
        .rdData        (rdData),
        .bufWriteEnable(bufWriteEnable),
        .bufWrite      (bufWrite),
        .bufReadEnable (bufReadEnable),
        .bufReadAck    (bufReadAck),
        .bufRead       (bufRead),
        .level         (level),
        .full          (full),
        .empty         (empty),
        .o_dbg_state   (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- environment state ----------------
    logic [WS-1:0] rq [NR][$];
    logic [WS-1:0] buf_q[$];
    logic [WS-1:0] exp_q[$];
    int            grant_q[$];
    logic [WS-1:0] rd_log[$];
    int            rd_pct   = 0;
    bit            rst_req  = 1'b1;
    logic [NR-1:0] pend_pop = '0;
    bit            pend_rd  = 1'b0;

    // what was driven during the previous cycle (sampled by the DUT at this edge)
    bit            p_reset  = 1'b1;
    logic [NR-1:0] p_valid  = '0;
    logic [WS-1:0] p_data [NR];
    bit            p_rdreq  = 1'b0;
    bit            p_bufack = 1'b0;
    logic [WS-1:0] p_bufread = '0;

    // reference model: occupancy count, rotation pointer, alternation flag, read countdown
    int            m_level      = 0;
    int            m_last       = NR - 1;
    int            m_rd_phase   = 0;
    bit            m_last_write = 1'b0;
    logic [NR-1:0] m_prev_ack   = '0;
    logic [WS-1:0] m_wdata      = '0;
    logic [WS-1:0] m_rddata     = '0;
    logic [NR-1:0] e_ack;
    bit            e_we, e_re, e_rv;

    task automatic predict();
        logic [NR-1:0] avail;
        bit wc, rc;
        int w;
        e_ack = '0; e_we = 1'b0; e_re = 1'b0; e_rv = 1'b0;
        if (p_reset) begin
            m_level = 0; m_last = NR - 1; m_rd_phase = 0; m_last_write = 1'b0;
            m_wdata = '0; m_rddata = '0;
        end else if (m_rd_phase == 2) begin
            m_rd_phase = 1;
        end else if (m_rd_phase == 1) begin
            m_rd_phase = 0;
            if (p_bufack) begin
                e_rv = 1'b1; m_rddata = p_bufread; m_level--;
            end
        end else begin
            avail = p_valid & ~m_prev_ack;
            wc = (avail != '0) && (m_level < BL);
            rc = p_rdreq && (m_level > 0);
            if (wc && (!rc || !m_last_write)) begin
                w = -1;
                for (int k = 1; k <= NR; k++)
                    if (w < 0 && avail[(m_last + k) % NR]) w = (m_last + k) % NR;
                e_ack[w] = 1'b1; e_we = 1'b1; m_wdata = p_data[w];
                m_last = w; m_level++; m_last_write = 1'b1;
            end else if (rc) begin
                e_re = 1'b1; m_rd_phase = 2; m_last_write = 1'b0;
            end
        end
        m_prev_ack = e_ack;
    endtask

    task automatic compare();
        check("ack", reqAck, e_ack);
        check("buf_we", bufWriteEnable, e_we);
        check("buf_wdata", bufWrite, m_wdata);
        check("buf_re", bufReadEnable, e_re);
        check("we_re_excl", bufWriteEnable & bufReadEnable, 0);
        check("rd_valid", rdValid, e_rv);
        check("rd_data", rdData, m_rddata);
        check("level", level, m_level);
        check("full", full, m_level == BL);
        check("empty", empty, m_level == 0);
        check("state", dbg_state == ST_READ_WAIT, m_rd_phase != 0);
    endtask

    // requesters, ring buffer model and scoreboard react to what the DUT shows
    task automatic env();
        if (p_reset) begin
            buf_q.delete(); exp_q.delete(); pend_rd = 1'b0;
        end
        for (int i = 0; i < NR; i++)
            if (pend_pop[i] && rq[i].size() != 0) void'(rq[i].pop_front());
        pend_pop = reqAck;
        for (int i = 0; i < NR; i++)
            if (reqAck[i] && rq[i].size() != 0) begin
                exp_q.push_back(rq[i][0]);
                grant_q.push_back(i);
            end
        if (bufWriteEnable) buf_q.push_back(bufWrite);
        if (rdValid) begin
            check("sb_has_entry", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                rd_log.push_back(rdData);
                check("sb_data", rdData, exp_q.pop_front());
            end
        end
    endtask

    task automatic drive();
        reset = rst_req;
        for (int i = 0; i < NR; i++) begin
            reqValid[i] = (rq[i].size() != 0);
            reqData[i*WS +: WS] = (rq[i].size() != 0) ? rq[i][0] : WS'($urandom);
        end
        rdReq = ($urandom_range(99) < rd_pct);
        if (pend_rd) begin
            bufReadAck = 1'b1;
            bufRead    = (buf_q.size() != 0) ? buf_q.pop_front() : 8'hEE;
        end else begin
            bufReadAck = 1'b0;
            bufRead    = WS'($urandom);
        end
        pend_rd   = bufReadEnable;
        p_reset   = reset;
        p_valid   = reqValid;
        for (int i = 0; i < NR; i++) p_data[i] = reqData[i*WS +: WS];
        p_rdreq   = rdReq;
        p_bufack  = bufReadAck;
        p_bufread = bufRead;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        predict();
        compare();
        env();
        drive();
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        cycle();
        rst_req = 1'b0;
        cycle();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int waited;
        for (int i = 0; i < NR; i++) p_data[i] = '0;
        reset = 1'b1; reqValid = '0; reqData = '0; rdReq = 1'b0;
        bufReadAck = 1'b0; bufRead = '0;
        rst_req = 1'b1;
        drive();
        repeat (3) cycle();
        check("reset_level", level, 0);
        check("reset_empty", empty, 1);
        check("reset_ack", reqAck, 0);
        check("reset_rdvalid", rdValid, 0);
        rst_req = 1'b0;
        cycle();

        // single write from requester 0
        rq[0].push_back(8'h5A);
        cycle();
        cycle();
        check("single_we", bufWriteEnable, 1);
        check("single_data", bufWrite, 8'h5A);
        check("single_ack", reqAck, 4'b0001);
        check("single_level", level, 1);
        rd_pct = 100;
        repeat (6) cycle();
        check("single_drained", empty, 1);
        rd_pct = 0;

        // fairness with all requesters held, then full
        do_reset();
        grant_q.delete();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NR; i++) rq[i].push_back(WS'(16 * i + k + 1));
        repeat (12) cycle();
        check("fair_count", grant_q.size(), 8);
        for (int k = 0; k < 8 && k < grant_q.size(); k++) check("fair_order", grant_q[k], k % NR);
        check("full_after_8", full, 1);
        rq[1].push_back(8'h77);
        repeat (5) cycle();
        check("full_hold_ack", reqAck, 0);
        check("full_no_we", bufWriteEnable, 0);
        check("full_level", level, BL);
        rd_pct = 100;
        repeat (60) cycle();
        check("full_drained", empty, 1);
        rd_pct = 0;

        // ordered reads of A1, B2
        do_reset();
        rq[2].push_back(8'hA1);
        rq[2].push_back(8'hB2);
        repeat (5) cycle();
        check("ab_level", level, 2);
        rd_log.delete();
        rd_pct = 100;
        repeat (14) cycle();
        check("ab_count", rd_log.size(), 2);
        if (rd_log.size() == 2) begin
            check("ab_first", rd_log[0], 8'hA1);
            check("ab_second", rd_log[1], 8'hB2);
        end
        check("ab_empty", empty, 1);
        check("ab_no_read", bufReadEnable, 0);
        rd_pct = 0;

        // contention: level 3 then a held writer against a held reader
        for (int k = 0; k < 3; k++) rq[0].push_back(WS'(8'h30 + k));
        repeat (10) cycle();
        check("cont_level", level, 3);
        for (int k = 0; k < 6; k++) rq[0].push_back(WS'(8'h40 + k));
        rd_pct = 100;
        repeat (30) cycle();
        rd_pct = 0;

        // randomized traffic
        for (int blk = 0; blk < 30; blk++) begin
            rd_pct = $urandom_range(0, 100);
            repeat (50) begin
                for (int i = 0; i < NR; i++)
                    if (rq[i].size() < 3 && $urandom_range(99) < 30) rq[i].push_back(WS'($urandom));
                cycle();
            end
        end

        // reset while a read is in flight
        rd_pct = 0;
        rq[1].push_back(8'hC3);
        rq[1].push_back(8'hD4);
        repeat (10) cycle();
        rd_pct = 100;
        waited = 0;
        while (!bufReadEnable && waited < 40) begin
            cycle();
            waited++;
        end
        check("rw_read_seen", bufReadEnable, 1);
        rd_pct  = 0;
        rst_req = 1'b1;
        cycle();
        rst_req = 1'b0;
        cycle();
        check("rw_no_rdvalid", rdValid, 0);
        check("rw_level", level, 0);
        check("rw_state_idle", dbg_state == ST_IDLE, 1);

        // final drain
        rd_pct = 100;
        waited = 0;
        while (waited < 400 && !(rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0 &&
                                 rq[3].size() == 0 && m_level == 0 && m_rd_phase == 0)) begin
            cycle();
            waited++;
        end
        repeat (4) cycle();
        check("final_level", level, 0);
        check("final_sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
